mem_stage: RTL

- Pipeline ME stage, directly downstream of the EX/ME pipeline register; consumes its ALU result, store data, destination register and mem2reg/memwr/regwr controls.
- Runs loads and stores on an external data-memory bus with a req/ack handshake, stalls upstream while an access is in flight, and drives the ME/WB pipeline register.
- Detects misaligned word accesses and bus timeouts.

---
 rtl/mem_stage_if.sv | 19 +
 rtl/mem_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory bus between the ME stage (master) and the memory (slave).
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline ME stage: runs loads/stores over a req/ack bus, stalls upstream
// while an access is outstanding, flags misaligned accesses and bus timeouts,
// and drives the ME/WB pipeline register.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [31:0]        in_alu,
    input  logic [31:0]        in_store,
    input  logic [4:0]         in_dst,
    input  logic               in_mem2reg,
    input  logic               in_memwr,
    input  logic               in_regwr,
    output logic               stall,
    mem_stage_if.master        mem,
    output logic               wb_valid,
    output logic [31:0]        wb_data,
    output logic [4:0]         wb_dst,
    output logic               wb_regwr,
    output logic               exc_align,
    output logic               bus_err,
    output logic [31:0]        exc_addr
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               wb_valid_q, wb_valid_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic [4:0]         wb_dst_q, wb_dst_d;
    logic               wb_regwr_q, wb_regwr_d;
    logic               exc_align_q, exc_align_d;
    logic               bus_err_q, bus_err_d;
    logic [31:0]        exc_addr_q, exc_addr_d;

    logic memop;
    logic aligned;

    assign memop   = in_mem2reg | in_memwr;
    assign aligned = (in_alu[1:0] == 2'b00);

    // Upstream stall; gated by reset so it drops together with the flops.
    always_comb begin
        stall = 1'b0;
        if (rst) begin
            stall = (state_q == S_ACCESS) ||
                    ((state_q == S_IDLE) && in_valid && memop && aligned);
        end
    end

    // Next-state and next-output computation for the ME stage.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_dst_d    = wb_dst_q;
        wb_regwr_d  = 1'b0;
        exc_align_d = 1'b0;
        bus_err_d   = 1'b0;
        exc_addr_d  = exc_addr_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (!memop) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = in_alu;
                        wb_dst_d   = in_dst;
                        wb_regwr_d = in_regwr;
                    end else if (!aligned) begin
                        wb_valid_d  = 1'b1;
                        wb_data_d   = in_alu;
                        wb_dst_d    = in_dst;
                        exc_align_d = 1'b1;
                        exc_addr_d  = in_alu;
                    end else begin
                        state_d = S_ACCESS;
                        req_d   = 1'b1;
                        we_d    = in_memwr;
                        addr_d  = {in_alu[31:2], 2'b00};
                        wdata_d = in_store;
                        cnt_d   = '0;
                    end
                end
            end
            S_ACCESS: begin
                // Ack is tested first so an ack on the timeout cycle wins.
                if (mem.mem_ack) begin
                    req_d   = 1'b0;
                    rdata_d = mem.mem_rdata;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d      = 1'b0;
                    err_d      = 1'b1;
                    bus_err_d  = 1'b1;
                    exc_addr_d = addr_q;
                    state_d    = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d    = S_IDLE;
                wb_valid_d = 1'b1;
                wb_dst_d   = in_dst;
                wb_data_d  = in_mem2reg ? rdata_q : in_alu;
                wb_regwr_d = in_regwr & ~err_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_dst_q    <= '0;
            wb_regwr_q  <= 1'b0;
            exc_align_q <= 1'b0;
            bus_err_q   <= 1'b0;
            exc_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_dst_q    <= wb_dst_d;
            wb_regwr_q  <= wb_regwr_d;
            exc_align_q <= exc_align_d;
            bus_err_q   <= bus_err_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_dst        = wb_dst_q;
    assign wb_regwr      = wb_regwr_q;
    assign exc_align     = exc_align_q;
    assign bus_err       = bus_err_q;
    assign exc_addr      = exc_addr_q;

endmodule
